// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: drives columns one-hot active-low, debounces the rows,
// encodes the key and holds it until the reader acknowledges it.
module escaner_teclado #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       ack_read
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_TICKS + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_ONE  = CNT_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_TICKS - 1);
    localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_ZERO  = DEB_W'(0);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_VALID    = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Lowest-index low row wins; only called with at least one row low.
    function automatic logic [3:0] encode_key(input logic [3:0] rows_n,
                                              input logic [1:0] col_idx);
        logic [1:0] row;
        logic [3:0] code;
        if (rows_n[0] == 1'b0) begin
            row = 2'd0;
        end else if (rows_n[1] == 1'b0) begin
            row = 2'd1;
        end else if (rows_n[2] == 1'b0) begin
            row = 2'd2;
        end else begin
            row = 2'd3;
        end
        case ({row, col_idx})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
        return ~(4'b0001 << col_idx);
    endfunction

    logic [3:0]       fil_meta_r;
    logic [3:0]       fil_sync_r;
    logic [CNT_W-1:0] slot_cnt_r;
    logic             tick_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       col_idx_r;
    logic [1:0]       col_idx_nxt_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_cnt_nxt_s;
    logic [3:0]       ref_r;
    logic [3:0]       ref_nxt_s;
    logic [3:0]       code_nxt_s;
    logic             valid_nxt_s;
    logic [3:0]       col_nxt_s;

    // Two-flop synchronizer; resets to "no row pulled low".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fil_meta_r <= 4'hF;
            fil_sync_r <= 4'hF;
        end else begin
            fil_meta_r <= fil;
            fil_sync_r <= fil_meta_r;
        end
    end

    // Free-running column slot counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_r <= '0;
        end else if (slot_cnt_r == SLOT_LAST) begin
            slot_cnt_r <= '0;
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_ONE;
        end
    end

    assign tick_s = (slot_cnt_r == SLOT_LAST);

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_SCAN;
            col_idx_r <= 2'd0;
            deb_cnt_r <= DEB_ZERO;
            ref_r     <= 4'hF;
            col       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            col_idx_r <= col_idx_nxt_s;
            deb_cnt_r <= deb_cnt_nxt_s;
            ref_r     <= ref_nxt_s;
            col       <= col_nxt_s;
            key_code  <= code_nxt_s;
            key_valid <= valid_nxt_s;
        end
    end

    // Next-state logic; the column only moves in SCAN or when leaving a frozen state.
    always_comb begin
        state_nxt_s   = state_r;
        col_idx_nxt_s = col_idx_r;
        deb_cnt_nxt_s = deb_cnt_r;
        ref_nxt_s     = ref_r;
        code_nxt_s    = key_code;
        valid_nxt_s   = key_valid;
        case (state_r)
            ST_SCAN: begin
                if (tick_s) begin
                    if (fil_sync_r == 4'hF) begin
                        col_idx_nxt_s = col_idx_r + 2'd1;
                    end else begin
                        ref_nxt_s     = fil_sync_r;
                        deb_cnt_nxt_s = DEB_ZERO;
                        state_nxt_s   = ST_DEBOUNCE;
                    end
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (tick_s) begin
                    if (fil_sync_r == ref_r) begin
                        if (deb_cnt_r == DEB_LAST) begin
                            code_nxt_s    = encode_key(ref_r, col_idx_r);
                            valid_nxt_s   = 1'b1;
                            deb_cnt_nxt_s = DEB_ZERO;
                            state_nxt_s   = ST_VALID;
                        end else begin
                            deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
                        end
                    end else begin
                        col_idx_nxt_s = col_idx_r + 2'd1;
                        state_nxt_s   = ST_SCAN;
                    end
                end else begin
                    state_nxt_s = ST_DEBOUNCE;
                end
            end
            ST_VALID: begin
                if (key_valid && ack_read) begin
                    valid_nxt_s   = 1'b0;
                    deb_cnt_nxt_s = DEB_ZERO;
                    state_nxt_s   = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_VALID;
                end
            end
            ST_RELEASE: begin
                if (tick_s) begin
                    if (fil_sync_r == 4'hF) begin
                        if (deb_cnt_r == DEB_LAST) begin
                            deb_cnt_nxt_s = DEB_ZERO;
                            col_idx_nxt_s = col_idx_r + 2'd1;
                            state_nxt_s   = ST_SCAN;
                        end else begin
                            deb_cnt_nxt_s = deb_cnt_r + DEB_ONE;
                        end
                    end else begin
                        deb_cnt_nxt_s = DEB_ZERO;
                    end
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s   = ST_SCAN;
                col_idx_nxt_s = 2'd0;
                deb_cnt_nxt_s = DEB_ZERO;
                valid_nxt_s   = 1'b0;
            end
        endcase
        col_nxt_s = col_drive(col_idx_nxt_s);
    end

endmodule

// File: tb/tb_escaner_teclado.sv
// Directed bench for escaner_teclado with SCAN_DIV=4, DEB_TICKS=2 and a
// behavioural keypad matrix driven by the scanned columns.
module tb_escaner_teclado;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fil;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       ack_read = 1'b0;

    logic [3:0] press [4];
    logic       ovr_en  = 1'b0;
    logic [3:0] ovr_val = 4'hF;
    logic [3:0] kp_s;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [3:0] col_seq [4];

    escaner_teclado #(.SCAN_DIV(4), .DEB_TICKS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .fil       (fil),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .ack_read  (ack_read)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kp_s = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col[c] == 1'b0) kp_s = kp_s & ~press[c];
        end
        fil = ovr_en ? ovr_val : kp_s;
    end

    task automatic step();
        @(negedge clk);
        n = n + 1;
    endtask

    task automatic goto(input int t);
        while (n < t) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
    endtask

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) press[c] = 4'h0;
    endtask

    task automatic test_reset();
        clear_keys();
        ack_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: col=%b valid=%b code=%h expected col=1110 valid=0 code=0",
                     col, key_valid, key_code);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k <= 16; k++) begin
            goto(k);
            total++;
            if (col !== col_seq[(k / 4) % 4] || key_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_scan n=%0d: col=%b valid=%b expected col=%b valid=0",
                         k, col, key_valid, col_seq[(k / 4) % 4]);
            end
        end
    endtask

    task automatic test_key5_hold_ack();
        logic dropped;
        clear_keys();
        press[1] = 4'b0010;
        do_reset();
        goto(15);
        total++;
        if (key_valid !== 1'b0) begin
            bad++;
            $display("FAIL key5_early: valid=%b expected 0", key_valid);
        end
        goto(16);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h5 || col !== 4'b1101) begin
            bad++;
            $display("FAIL key5_valid: valid=%b code=%h col=%b expected 1 5 1101",
                     key_valid, key_code, col);
        end
        clear_keys();
        dropped = 1'b0;
        for (int k = 17; k <= 66; k++) begin
            goto(k);
            if (key_valid !== 1'b1 || key_code !== 4'h5) dropped = 1'b1;
        end
        total++;
        if (dropped !== 1'b0 || col !== 4'b1101) begin
            bad++;
            $display("FAIL key5_hold: dropped=%b col=%b expected 0 1101", dropped, col);
        end
        ack_read = 1'b1;
        step();
        ack_read = 1'b0;
        total++;
        if (key_valid !== 1'b0) begin
            bad++;
            $display("FAIL key5_ack: valid=%b expected 0", key_valid);
        end
        goto(71);
        total++;
        if (col !== 4'b1101) begin
            bad++;
            $display("FAIL key5_release_hold: col=%b expected 1101", col);
        end
        goto(72);
        total++;
        if (col !== 4'b1011) begin
            bad++;
            $display("FAIL key5_release_advance: col=%b expected 1011", col);
        end
    endtask

    task automatic test_bounce();
        logic seen;
        clear_keys();
        ovr_en  = 1'b1;
        ovr_val = 4'b1110;
        do_reset();
        seen = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            goto(k);
            if (k == 4) ovr_val = 4'hF;
            if (key_valid !== 1'b0) seen = 1'b1;
            if (k == 5 || k == 7 || k == 8 || k == 12) begin
                total++;
                if (col !== ((k < 8) ? 4'b1110 : ((k == 8) ? 4'b1101 : 4'b1011))) begin
                    bad++;
                    $display("FAIL bounce_col n=%0d: col=%b", k, col);
                end
            end
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL bounce_valid: valid seen=%b expected 0", seen);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_key(input string name, input int c, input logic [3:0] rows,
                            input logic [3:0] exp_code);
        int t;
        clear_keys();
        press[c] = rows;
        do_reset();
        t = 4 * c + 12;
        goto(t - 1);
        total++;
        if (key_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_early: valid=%b expected 0", name, key_valid);
        end
        goto(t);
        total++;
        if (key_valid !== 1'b1 || key_code !== exp_code) begin
            bad++;
            $display("FAIL %s: valid=%b code=%h expected 1 %h", name, key_valid, key_code, exp_code);
        end
    endtask

    task automatic test_ack_high();
        int rises;
        logic prev;
        logic [3:0] got;
        clear_keys();
        press[1] = 4'b1000;
        ack_read = 1'b1;
        do_reset();
        rises = 0;
        prev  = 1'b0;
        got   = 4'hA;
        for (int k = 0; k <= 150; k++) begin
            goto(k);
            if (k == 30) clear_keys();
            if (key_valid === 1'b1) begin
                got = key_code;
                if (prev == 1'b0) rises++;
            end
            prev = key_valid;
        end
        ack_read = 1'b0;
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL ack_high_pulses: got %0d expected 1", rises);
        end
        total++;
        if (got !== 4'h0) begin
            bad++;
            $display("FAIL ack_high_code: got %h expected 0", got);
        end
    endtask

    task automatic test_ack_idle();
        clear_keys();
        press[0] = 4'b0001;
        ack_read = 1'b1;
        do_reset();
        goto(5);
        ack_read = 1'b0;
        goto(12);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'h1) begin
            bad++;
            $display("FAIL ack_idle_valid: valid=%b code=%h expected 1 1", key_valid, key_code);
        end
        goto(30);
        total++;
        if (key_valid !== 1'b1) begin
            bad++;
            $display("FAIL ack_idle_hold: valid=%b expected 1", key_valid);
        end
    endtask

    task automatic test_reset_valid();
        clear_keys();
        press[0] = 4'b1000;
        ack_read = 1'b0;
        do_reset();
        goto(13);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'hE) begin
            bad++;
            $display("FAIL rst_valid_pre: valid=%b code=%h expected 1 E", key_valid, key_code);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (key_valid !== 1'b0 || col !== 4'b1110 || key_code !== 4'h0) begin
            bad++;
            $display("FAIL rst_valid_async: valid=%b col=%b code=%h expected 0 1110 0",
                     key_valid, col, key_code);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_keys();
        n = 0;
    endtask

    initial begin
        col_seq[0] = 4'b1110;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111;
        clear_keys();
        test_reset();
        test_key5_hold_ack();
        test_bounce();
        test_key("star", 0, 4'b1000, 4'hE);
        test_key("hash", 2, 4'b1000, 4'hF);
        test_key("one_four", 0, 4'b0011, 4'h1);
        test_key("key_d", 3, 4'b1000, 4'hD);
        test_ack_high();
        test_ack_idle();
        test_reset_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: every wait above is cycle-bounded, this only guards the bench itself.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
